// File: rtl/xt_lbus_master.sv
// -----------------------------------------------------------------------------
// xt_lbus_master
//
// Initiator end of the XT local bus (LBUS). Takes one read or write request at
// a time from the core-side valid/ready channel, runs exactly one LBUS strobe
// cycle for it, then captures the OR-reduced slave read data. The captured
// data is returned on the valid/ready response channel.
//
// Transaction flow: IDLE -> STROBE (one cycle) -> RESP -> IDLE.
//
// Optional feature (macro XT_LBUS_MASTER_POSTED_WRITE_EN):
//   When the macro is defined, writes are posted. A write goes from STROBE
//   straight back to IDLE and never raises rsp_valid. Reads are unchanged.
//   When the macro is undefined, every write returns a response with
//   rsp_rdata = 0.
//
// Ports:
//   lb_clk     in   LBUS clock; all logic runs on its rising edge
//   lb_rst_n   in   asynchronous active-low reset
//   req_valid  in   core request valid
//   req_ready  out  request accepted when req_valid && req_ready
//   req_write  in   1 = write, 0 = read
//   req_addr   in   [ADDR_W] target LBUS address
//   req_wdata  in   [DATA_W] write data
//   rsp_valid  out  response valid
//   rsp_ready  in   core accepts the response
//   rsp_rdata  out  [DATA_W] read data; 0 for writes
//   xt_lb      out  lb_slave_t LBUS broadcast {addr, wdata, we, re}
//   rdata_in   in   [DATA_W] OR of all slave rdata outputs
// -----------------------------------------------------------------------------

package xt_lbus_pkg;
  localparam int LB_ADDR_W = 8;
  localparam int LB_DATA_W = 32;

  typedef struct packed {
    logic [LB_ADDR_W-1:0] addr;
    logic [LB_DATA_W-1:0] wdata;
    logic                 we;
    logic                 re;
  } lb_slave_t;
endpackage

module xt_lbus_master
  import xt_lbus_pkg::*;
#(
  // Must match the field widths of lb_slave_t.
  parameter int ADDR_W = LB_ADDR_W,
  parameter int DATA_W = LB_DATA_W
) (
  input  logic              lb_clk,
  input  logic              lb_rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output lb_slave_t         xt_lb,
  input  logic [DATA_W-1:0] rdata_in
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_write;
  logic [DATA_W-1:0] r_rdata;
  logic              w_accept;
  logic              w_we;
  logic              w_re;

  assign w_accept = req_valid && req_ready;

  // State register. Because we/re are decoded from the state, an asynchronous
  // reset drops the strobe immediately, with no extra cycle of delay.
  always_ff @(posedge lb_clk or negedge lb_rst_n) begin
    if (!lb_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = ST_STROBE;
        end
      end
      ST_STROBE: begin
`ifdef XT_LBUS_MASTER_POSTED_WRITE_EN
        // A posted write has no response phase.
        w_state_next = r_write ? ST_IDLE : ST_RESP;
`else
        w_state_next = ST_RESP;
`endif
      end
      ST_RESP: begin
        // Returning through IDLE means the earliest next acceptance comes
        // one cycle after the response handshake.
        if (rsp_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    w_we      = 1'b0;
    w_re      = 1'b0;
    case (r_state)
      ST_IDLE:   req_ready = 1'b1;
      ST_STROBE: begin
        w_we = r_write;
        w_re = !r_write;
      end
      ST_RESP:   rsp_valid = 1'b1;
      default:   req_ready = 1'b0;
    endcase
  end

  // Request capture and response data. The bus address and write data are
  // only updated on acceptance, so they hold their last value outside STROBE.
  always_ff @(posedge lb_clk or negedge lb_rst_n) begin
    if (!lb_rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (r_state == ST_IDLE && w_accept) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_write <= req_write;
      end
      // rdata_in is meaningful only during the strobe of a read. Writes
      // return zero.
      if (r_state == ST_STROBE) begin
        r_rdata <= r_write ? '0 : rdata_in;
      end
    end
  end

  assign rsp_rdata   = r_rdata;
  assign xt_lb.addr  = r_addr;
  assign xt_lb.wdata = r_wdata;
  assign xt_lb.we    = w_we;
  assign xt_lb.re    = w_re;

endmodule

// File: tb/tb_xt_lbus_master.sv
module tb_xt_lbus_master;
  import xt_lbus_pkg::*;

  logic        lb_clk;
  logic        lb_rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  lb_slave_t   xt_lb;
  logic [31:0] rdata_in;
  logic [31:0] rd_noise;

  int n_tests = 0;
  int n_fail  = 0;
  int re_cnt;
  int rsp_cnt;

  xt_lbus_master #(.ADDR_W(8), .DATA_W(32)) dut (
    .lb_clk    (lb_clk),
    .lb_rst_n  (lb_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .xt_lb     (xt_lb),
    .rdata_in  (rdata_in)
  );

  initial lb_clk = 1'b0;
  always #5 lb_clk = ~lb_clk;

  // Slave model: address 20 returns 0xA5 and address 21 returns 0x5A5A0021,
  // but only while re is high. At all other times rd_noise appears on the
  // bus, so the DUT must ignore it.
  always_comb begin
    rdata_in = rd_noise;
    if (xt_lb.re) begin
      if (xt_lb.addr == 8'd20)      rdata_in = 32'h0000_00A5;
      else if (xt_lb.addr == 8'd21) rdata_in = 32'h5A5A_0021;
      else                          rdata_in = 32'h0;
    end
  end

  task automatic tick();
    @(posedge lb_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("[TB] t=%0t %s observed=%0h expected=%0h", $time, tag, obs, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    lb_rst_n  = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 8'h0;
    req_wdata = 32'h0;
    rsp_ready = 1'b0;
    rd_noise  = 32'h0;
    tick();
    tick();

    // Reset state
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_we", xt_lb.we, 0);
    chk("rst_re", xt_lb.re, 0);
    chk("rst_addr", xt_lb.addr, 0);
    chk("rst_wdata", xt_lb.wdata, 0);
    lb_rst_n = 1'b1;
    tick();

    // Write to address 20. Noise is driven on rdata_in and must be ignored.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'd20; req_wdata = 32'hA5;
    rd_noise  = 32'h1234_5678;
    tick();                                   // accepted at edge N
    req_valid = 1'b0;
    chk("wr_we", xt_lb.we, 1);
    chk("wr_re", xt_lb.re, 0);
    chk("wr_addr", xt_lb.addr, 8'd20);
    chk("wr_wdata", xt_lb.wdata, 32'hA5);
    chk("wr_req_ready_strobe", req_ready, 0);
    tick();                                   // edge N+1
    chk("wr_we_drop", xt_lb.we, 0);
    chk("wr_addr_hold", xt_lb.addr, 8'd20);
`ifdef XT_LBUS_MASTER_POSTED_WRITE_EN
    chk("wr_posted_no_rsp", rsp_valid, 0);
    chk("wr_posted_ready", req_ready, 1);
`else
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_rsp_rdata", rsp_rdata, 0);
    rsp_ready = 1'b1;
    tick();                                   // handshake
    chk("wr_rsp_done", rsp_valid, 0);
    chk("wr_ready_again", req_ready, 1);
`endif
    rsp_ready = 1'b0;
    rd_noise  = 32'h0;

    // Read from address 20, then change rdata_in to check the response holds.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'd20; req_wdata = 32'h55;
    tick();
    req_valid = 1'b0;
    chk("rd_re", xt_lb.re, 1);
    chk("rd_we", xt_lb.we, 0);
    tick();
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_rdata", rsp_rdata, 32'hA5);
    chk("rd_re_drop", xt_lb.re, 0);
    rd_noise = 32'hDEAD_BEEF;
    tick();
    chk("rd_rdata_stable", rsp_rdata, 32'hA5);
    chk("rd_valid_stable", rsp_valid, 1);
    rsp_ready = 1'b1;
    tick();
    chk("rd_rsp_done", rsp_valid, 0);
    rsp_ready = 1'b0;
    rd_noise  = 32'h0;

    // Read an unmapped address: expect zero data and no hang.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'hFF;
    tick();
    req_valid = 1'b0;
    chk("unm_re", xt_lb.re, 1);
    tick();
    chk("unm_rsp_valid", rsp_valid, 1);
    chk("unm_rsp_rdata", rsp_rdata, 0);
    rsp_ready = 1'b1;
    tick();
    chk("unm_rsp_done", rsp_valid, 0);
    rsp_ready = 1'b0;

    // Backpressure on the response while req_valid stays high
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'd20;
    tick();                                   // accepted
    tick();                                   // RESP
    re_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (xt_lb.re) re_cnt++;
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_rdata", rsp_rdata, 32'hA5);
      chk("bp_req_ready", req_ready, 0);
      tick();
    end
    chk("bp_no_strobe", re_cnt, 0);
    rsp_ready = 1'b1;
    tick();                                   // handshake at edge H
    chk("bp_idle_valid", rsp_valid, 0);
    chk("bp_idle_ready", req_ready, 1);
    tick();                                   // accepted at edge H+1
    req_valid = 1'b0;
    chk("bp_next_re", xt_lb.re, 1);
    tick();
    chk("bp_next_rsp", rsp_valid, 1);
    tick();                                   // handshake (rsp_ready high)
    chk("bp_next_done", rsp_valid, 0);

    // Four back-to-back reads alternating between addresses 20 and 21
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'd20;
    rsp_ready = 1'b1;
    re_cnt  = 0;
    rsp_cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 12) req_valid = 1'b0;
      chk("b2b_re", xt_lb.re, (i % 3 == 1));
      chk("b2b_rsp_valid", rsp_valid, (i % 3 == 2));
      if (xt_lb.re) begin
        re_cnt++;
        req_addr = (re_cnt % 2 == 1) ? 8'd21 : 8'd20;
      end
      if (rsp_valid) begin
        chk("b2b_rsp_rdata", rsp_rdata,
            (rsp_cnt % 2 == 0) ? 32'h0000_00A5 : 32'h5A5A_0021);
        rsp_cnt++;
      end
    end
    chk("b2b_re_count", re_cnt, 4);
    chk("b2b_rsp_count", rsp_cnt, 4);
    rsp_ready = 1'b0;

    // Assert reset during STROBE
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h33; req_wdata = 32'h77;
    tick();
    req_valid = 1'b0;
    chk("mid_we", xt_lb.we, 1);
    #1 lb_rst_n = 1'b0;
    #1;
    chk("mid_we_drop", xt_lb.we, 0);
    chk("mid_re_drop", xt_lb.re, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_addr_rst", xt_lb.addr, 0);
    tick();
    lb_rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_ready", req_ready, 1);
      chk("post_rst_no_rsp", rsp_valid, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
